mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Bus initiator that fills the instruction/data RAM from a word stream before the CPU runs.
//  - Drives the same addr/MemRead/MemWrite/WrData/data interface the CPU uses; shares the memory block via an external mux selected by cpu_hold.
//  - Accepts words on a valid/ready stream and writes them to consecutive word addresses starting at BASE_ADDR.
//  - Holds the CPU off while loading.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of first word; bits [1:0] must be 00
//  DEPTH_WORDS 256            RAM capacity in words (addr[9:2]); max legal load length
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   begin load; sampled only in IDLE
//  len        in   9   words to load; sampled with start
//  in_valid   in   1   stream word valid
//  in_data    in   32  stream word
//  in_ready   out  1   loader can accept a word this cycle
//  addr       out  32  byte address to memory
//  MemRead    out  1   memory read strobe (verify only)
//  MemWrite   out  1   memory write strobe
//  WrData     out  32  write data to memory
//  data       in   32  memory read data, valid 1 cycle after MemRead/addr
//  cpu_hold   out  1   high while loading; gates the CPU off the bus
//  done       out  1   1-cycle pulse at end of load
//  error      out  1   sticky fault flag; cleared by accepted start or rst
//  word_count out  9   words written so far in current or last load
// BEHAVIOUR
//  - Reset (next edge after rst=1):
//    - State IDLE.
//    - All outputs 0, including word_count and error.
//    - Any in-flight write is abandoned; no strobe is issued in the cycle after rst.
//  - States: IDLE, WAIT_WORD, WRITE, DONE (+ VRD, VCHK with verify).
//  - IDLE:
//    - start=1 & len in 1..DEPTH_WORDS -> latch len, idx=0, error=0 -> WAIT_WORD.
//    - start=1 & len=0 -> DONE, no writes.
//    - start=1 & len>DEPTH_WORDS -> error=1 -> DONE, no writes.
//  - WAIT_WORD:
//    - in_ready=1.
//    - Word is transferred when in_valid & in_ready; it is latched into WrData -> WRITE.
//    - in_valid low: stay; no timeout.
//  - WRITE:
//    - MemWrite=1 for exactly 1 cycle; addr = BASE_ADDR + {idx,2'b00}.
//    - idx and word_count increment at end of cycle.
//    - If idx was len-1 -> DONE, else -> WAIT_WORD.
//  - DONE: done=1 for one cycle -> IDLE.
//  - in_ready=0 in every state except WAIT_WORD.
//  - cpu_hold=1 in every state except IDLE.
//  - MemRead=0, MemWrite=0, addr=0 except in the states that drive them.
//  - WrData holds the last latched word.
//  - Throughput: 1 word / 2 cycles when in_valid is held high (verify off). Latency: start -> first MemWrite = 2 cycles with in_valid high.
//  - start while not IDLE is ignored.
//  - rst mid-load: memory contents already written stay; the load is not resumed.
//  - Address arithmetic is 32-bit unsigned; BASE_ADDR + 4*(DEPTH_WORDS-1) must not cross into the I/O region (integration constraint).
// CONFIGURATION
//  LOADER_VERIFY_EN
//   - Defined: WRITE -> VRD -> VCHK.
//     - VRD: MemRead=1 at the same addr.
//     - VCHK: compare data with WrData; on mismatch, error=1 (sticky) and the load continues.
//     - From VCHK: -> DONE if last word, else -> WAIT_WORD.
//     - Throughput: 1 word / 4 cycles.
//   - Undefined:
//     - VRD and VCHK do not exist; MemRead is tied to 0.
//     - data is unused; error is set only by illegal len.
// TESTING
//  - rst held 2 cycles mid-load (after 2 of 5 writes) -> next cycle all outputs 0; state IDLE; later start works normally.
//  - start, len=3, words 0xA,0xB,0xC, in_valid high -> MemWrite at addr BASE+0,+4,+8 with matching WrData; done pulse; word_count=3; error=0.
//  - len=2, in_valid gaps of 5 cycles -> no MemWrite during gaps; in_ready stays 1; done only after 2nd write.
//  - start with len=0 -> done next cycle, no MemWrite; start with len=257 -> error=1, done, no MemWrite.
//  - start asserted again during load -> ignored; len unchanged; single done.
//  - LOADER_VERIFY_EN: memory model corrupts word 1 (returns 0xDEAD) -> error=1 after VCHK, remaining words still written, done pulses.

Source files
------------

// File: rtl/mem_loader_if.sv
// Bus bundle between mem_loader and its surroundings: word stream in, memory bus out,
// plus the load control/status lines. master = loader side, slave = environment side.
interface mem_loader_if;
   logic        start;
   logic [8:0]  len;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [31:0] addr;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] WrData;
   logic [31:0] data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [8:0]  word_count;

   modport master (
      input  start, len, in_valid, in_data, data,
      output in_ready, addr, MemRead, MemWrite, WrData, cpu_hold, done, error, word_count
   );

   modport slave (
      output start, len, in_valid, in_data, data,
      input  in_ready, addr, MemRead, MemWrite, WrData, cpu_hold, done, error, word_count
   );
endinterface

// File: rtl/mem_loader.sv
// Streams words into RAM at consecutive addresses from BASE_ADDR while holding the CPU off.
// Optional read-back verify of every word is enabled by defining LOADER_VERIFY_EN.
module mem_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input logic          clk,
   input logic          rst,
   mem_loader_if.master bus
);

`ifdef LOADER_VERIFY_EN
   typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, DONE, VRD, VCHK} state_e;
`else
   typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_e;
`endif

   state_e      state_q, state_d;
   logic [8:0]  len_q, len_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        error_q, error_d;
   logic [8:0]  word_idx;
   logic        mem_write, mem_read, in_ready, done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         wr_data_q <= '0;
         error_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of order.
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         wr_data_q <= wr_data_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case infers a latch.
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_data_d = wr_data_q;
      error_d   = error_q;
      word_idx  = cnt_q;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      in_ready  = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d   = '0;
               error_d = 1'b0;
               if (bus.len == 9'd0) begin
                  state_d = DONE;
               end else if (32'(bus.len) > DEPTH_WORDS) begin
                  error_d = 1'b1;
                  state_d = DONE;
               end else begin
                  len_d   = bus.len;
                  state_d = WAIT_WORD;
               end
            end
         end
         WAIT_WORD: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               wr_data_d = bus.in_data;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            mem_write = 1'b1;
            cnt_d     = cnt_q + 9'd1;
`ifdef LOADER_VERIFY_EN
            state_d   = VRD;
`else
            state_d   = (cnt_q == len_q - 9'd1) ? DONE : WAIT_WORD;
`endif
         end
`ifdef LOADER_VERIFY_EN
         // The count already advanced in WRITE, so the word just written sits at cnt_q-1.
         VRD: begin
            mem_read = 1'b1;
            word_idx = cnt_q - 9'd1;
            state_d  = VCHK;
         end
         VCHK: begin
            if (bus.data != wr_data_q) error_d = 1'b1;
            state_d = (cnt_q == len_q) ? DONE : WAIT_WORD;
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifndef LOADER_VERIFY_EN
   logic unused_data;
   assign unused_data = ^bus.data;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.MemWrite   = mem_write;
   assign bus.MemRead    = mem_read;
   assign bus.addr       = (mem_write || mem_read) ? BASE_ADDR + {21'd0, word_idx, 2'b00} : 32'd0;
   assign bus.WrData     = wr_data_q;
   assign bus.cpu_hold   = (state_q != IDLE);
   assign bus.done       = done;
   assign bus.error      = error_q;
   assign bus.word_count = cnt_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: stream loads, gaps, illegal lengths, restart and mid-load reset.
// Define LOADER_VERIFY_EN for both RTL and bench to exercise the read-back verify path.
module tb_mem_loader;
   localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef LOADER_VERIFY_EN
   localparam int POST = 3;   // cycles from a WRITE to the next state that can take a word
`else
   localparam int POST = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_loader_if bus();
   mem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(256)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [256];
   logic        corrupt_w1 = 1'b0;
   int          cyc = 0;
   int          n_done = 0;
   int          done_cyc = 0;
   logic [31:0] wr_addr_q [$];
   logic [31:0] wr_dat_q  [$];
   int          wr_cyc_q  [$];
   logic [31:0] words     [$];

   function automatic logic [7:0] idx_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off[9:2];
   endfunction

   // Memory model: one-cycle read latency; optionally returns a bad word for index 1.
   always @(posedge clk) begin
      if (bus.MemWrite) mem[idx_of(bus.addr)] <= bus.WrData;
      if (bus.MemRead)  bus.data <= (corrupt_w1 && bus.addr == BASE + 32'd4) ? 32'h0000_DEAD
                                                                          : mem[idx_of(bus.addr)];
   end

   always @(posedge clk) begin
      cyc++;
      if (bus.MemWrite) begin
         wr_addr_q.push_back(bus.addr);
         wr_dat_q.push_back(bus.WrData);
         wr_cyc_q.push_back(cyc);
      end
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctl"}, {58'd0, bus.in_ready, bus.MemRead, bus.MemWrite,
                            bus.cpu_hold, bus.done, bus.error}, 64'd0);
      check({tag, "_addr"}, bus.addr, 0);
      check({tag, "_wrdata"}, bus.WrData, 0);
      check({tag, "_wcount"}, bus.word_count, 0);
   endtask

   task automatic start_load(input logic [8:0] l, output int c0);
      @(negedge clk);
      c0 = cyc;
      bus.start = 1'b1;
      bus.len   = l;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Offers words[0..n-1]; after each accepted word in_valid drops for 'gap' cycles.
   task automatic feed(input int n, input int gap, input string tag);
      int   k;
      int   idle;
      int   post;
      int   budget;
      logic acc;
      k = 0; idle = gap; post = 0; budget = 3000;
      while (k < n && budget > 0) begin
         if (idle > 0) begin
            bus.in_valid = 1'b0;
            if (post == 0) begin
               check({tag, "_gap_ready"}, bus.in_ready, 1);
               check({tag, "_gap_nowrite"}, bus.MemWrite, 0);
            end
            idle--;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[k];
         end
         if (post > 0) post--;
         acc = bus.in_ready && bus.in_valid;
         @(negedge clk);
         budget--;
         if (acc) begin
            k++;
            idle = gap;
            post = POST;
         end
      end
      bus.in_valid = 1'b0;
      check({tag, "_accepted"}, k, n);
   endtask

   task automatic wait_done(input int base, input string tag);
      int b;
      b = 200;
      while (n_done == base && b > 0) begin
         @(negedge clk);
         b--;
      end
      check({tag, "_done"}, n_done, base + 1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int nw0;
      int nd0;
      rst = 1'b1;
      bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      rst = 1'b0;

      // Basic load of three words with in_valid held high.
      words = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd3, c0);
      feed(3, 0, "A");
      wait_done(nd0, "A");
      check("A_nwr", wr_addr_q.size() - nw0, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("A_addr%0d", i), wr_addr_q[nw0+i], BASE + 32'(4*i));
         check($sformatf("A_data%0d", i), wr_dat_q[nw0+i], words[i]);
      end
      check("A_latency", wr_cyc_q[nw0] - c0, 3);
      check("A_thruput", wr_cyc_q[nw0+1] - wr_cyc_q[nw0], POST + 1);
      check("A_done_after_last", done_cyc - wr_cyc_q[nw0+2], POST);
      check("A_wcount", bus.word_count, 3);
      check("A_error", bus.error, 0);
      check("A_hold_released", bus.cpu_hold, 0);

      // Two words with 5-cycle in_valid gaps.
      words = '{32'h1111_0000, 32'h2222_0000};
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd2, c0);
      feed(2, 5, "B");
      wait_done(nd0, "B");
      check("B_nwr", wr_addr_q.size() - nw0, 2);
      check("B_addr1", wr_addr_q[nw0+1], BASE + 32'd4);
      check("B_data1", wr_dat_q[nw0+1], 32'h2222_0000);
      check("B_done_after_last", done_cyc - wr_cyc_q[nw0+1], POST);

      // len=0 and len=257: immediate done, no writes; the second raises error.
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd0, c0);
      check("C0_done", bus.done, 1);
      check("C0_hold", bus.cpu_hold, 1);
      @(negedge clk);
      check("C0_done_pulse", bus.done, 0);
      check("C0_error", bus.error, 0);
      check("C0_wcount", bus.word_count, 0);
      start_load(9'd257, c0);
      check("C257_done", bus.done, 1);
      check("C257_error", bus.error, 1);
      @(negedge clk);
      check("C257_error_sticky", bus.error, 1);
      check("C_nwr", wr_addr_q.size() - nw0, 0);
      check("C_ndone", n_done - nd0, 2);

      // start re-asserted during a load is ignored; error cleared by the accepted start.
      words = '{32'hCAFE_0001, 32'hCAFE_0002};
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd2, c0);
      check("D_error_cleared", bus.error, 0);
      bus.start = 1'b1; bus.len = 9'd7;
      feed(2, 0, "D");
      bus.start = 1'b0; bus.len = '0;
      wait_done(nd0, "D");
      repeat (4) @(negedge clk);
      check("D_single_done", n_done - nd0, 1);
      check("D_nwr", wr_addr_q.size() - nw0, 2);
      check("D_wcount", bus.word_count, 2);
      check("D_hold", bus.cpu_hold, 0);

      // Reset held two cycles after 2 of 5 writes, then a normal load.
      words = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
      nw0 = wr_addr_q.size();
      start_load(9'd5, c0);
      feed(2, 0, "E");
      @(negedge clk);
      check("E_two_written", wr_addr_q.size() - nw0, 2);
      rst = 1'b1;
      @(negedge clk);
      check_idle("E_rst1");
      @(negedge clk);
      rst = 1'b0;
      check_idle("E_rst2");
      check("E_no_more_writes", wr_addr_q.size() - nw0, 2);
      check("E_mem1", mem[1], 32'hE1);
      words = '{32'h0000_0055};
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd1, c0);
      feed(1, 0, "E2");
      wait_done(nd0, "E2");
      check("E2_addr", wr_addr_q[nw0], BASE);
      check("E2_data", wr_dat_q[nw0], 32'h0000_0055);
      check("E2_wcount", bus.word_count, 1);

      // Full-depth load.
      words.delete();
      for (int i = 0; i < 256; i++) words.push_back(32'h5A00_0000 + 32'(i * 3));
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd256, c0);
      feed(256, 0, "G");
      wait_done(nd0, "G");
      check("G_nwr", wr_addr_q.size() - nw0, 256);
      check("G_last_addr", wr_addr_q[nw0+255], BASE + 32'h3FC);
      check("G_last_data", wr_dat_q[nw0+255], 32'h5A00_0000 + 32'(255 * 3));
      check("G_wcount", bus.word_count, 256);
      check("G_error", bus.error, 0);

`ifdef LOADER_VERIFY_EN
      // Read-back of word 1 is corrupted: error set, load still completes.
      corrupt_w1 = 1'b1;
      words = '{32'h0000_0F00, 32'h0000_0F01, 32'h0000_0F02};
      nw0 = wr_addr_q.size(); nd0 = n_done;
      start_load(9'd3, c0);
      feed(3, 0, "F");
      wait_done(nd0, "F");
      corrupt_w1 = 1'b0;
      check("F_error", bus.error, 1);
      check("F_nwr", wr_addr_q.size() - nw0, 3);
      check("F_wcount", bus.word_count, 3);
      check("F_data2", wr_dat_q[nw0+2], 32'h0000_0F02);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
